// File: rtl/pc2drone_clk_pkg.sv
// Shared types and helpers for the PLL clock manager and its clock-enable dividers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pc2drone_clk_pkg;

  // Lock sequencing states
  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILISE = 2'd1,
    RUN       = 2'd2,
    FAULT     = 2'd3
  } clk_state_t;

  // Divisor loaded into every channel at reset (1 = enable every cycle)
  localparam logic [15:0] DEFAULT_DIV_INIT = 16'd1;

  // Channel-index width, never narrower than one bit
  function automatic int ch_idx_w(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/pc2drone_ce_div.sv
// One clock-enable channel: counts 0..D-1 and strobes ce at the wrap; D of 0/1 gives ce every enabled cycle.
// Latency: ce is registered, first strobe D cycles after en rises.
// Backpressure: none; a new divisor waits in a shadow register until the current period completes.
module pc2drone_ce_div
  import pc2drone_clk_pkg::*;
#(
  parameter int               DIV_W       = 16,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(DEFAULT_DIV_INIT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [DIV_W-1:0] value,
  output logic             ce
);

  logic [DIV_W-1:0] shadow_div;
  logic [DIV_W-1:0] active_div;
  logic [DIV_W-1:0] cnt;
  logic             wrap;

  // Divisors 0 and 1 wrap every cycle; otherwise wrap on the last count of the period
  assign wrap = (active_div <= DIV_W'(1)) || (cnt >= active_div - DIV_W'(1));

  // Shadow divisor: last write wins until the active divisor picks it up
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_div <= DEFAULT_DIV;
    end else if (load) begin
      shadow_div <= value;
    end
  end

  // Period counter; active divisor only changes at a wrap or while stopped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_div <= DEFAULT_DIV;
      cnt        <= '0;
      ce         <= 1'b0;
    end else if (!en) begin
      active_div <= shadow_div;
      cnt        <= '0;
      ce         <= 1'b0;
    end else if (wrap) begin
      active_div <= shadow_div;
      cnt        <= '0;
      ce         <= 1'b1;
    end else begin
      cnt        <= cnt + 1'b1;
      ce         <= 1'b0;
    end
  end

endmodule

// File: rtl/pc2drone_clkgen.sv
// PLL clock manager: lock synchroniser, lock-stability FSM, synchronous reset release, N_CH clock-enable channels.
// Latency: ready/rst_sync_n rise 2 + STABLE_CYCLES + 1 cycles after LOCK is seen; fall 3 cycles after LOCK drops.
// Backpressure: none; divisor writes to nonexistent channels are dropped.
module pc2drone_clkgen
  import pc2drone_clk_pkg::*;
#(
  parameter int               N_CH          = 4,
  parameter int               DIV_W         = 16,
  parameter int               STABLE_CYCLES = 1024,
  parameter logic [DIV_W-1:0] DEFAULT_DIV   = DIV_W'(DEFAULT_DIV_INIT),
  parameter int               LOSS_CNT_W    = 8
) (
  input  logic                      PLLOUTGLOBAL,
  input  logic                      RESET,
  input  logic                      LOCK,
  input  logic                      div_load,
  input  logic [ch_idx_w(N_CH)-1:0] div_ch,
  input  logic [DIV_W-1:0]          div_value,
  output logic                      rst_sync_n,
  output logic                      ready,
  output logic [N_CH-1:0]           ce,
  output logic                      lock_lost,
  output logic [LOSS_CNT_W-1:0]     loss_count
);

  localparam int                CH_IDX_W  = ch_idx_w(N_CH);
  localparam int                STAB_W    = $clog2(STABLE_CYCLES);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);

  logic              lock_m;
  logic              lock_s;
  clk_state_t        state;
  clk_state_t        state_nxt;
  logic [STAB_W-1:0] stab_cnt;
  logic [STAB_W-1:0] stab_nxt;
  logic              ce_en;

  // Two-flop synchroniser for the asynchronous PLL lock
  always_ff @(posedge PLLOUTGLOBAL or negedge RESET) begin
    if (!RESET) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= LOCK;
      lock_s <= lock_m;
    end
  end

  // FSM state and stability counter registers
  always_ff @(posedge PLLOUTGLOBAL or negedge RESET) begin
    if (!RESET) begin
      state    <= WAIT_LOCK;
      stab_cnt <= '0;
    end else begin
      state    <= state_nxt;
      stab_cnt <= stab_nxt;
    end
  end

  // Next state: require an unbroken run of lock before releasing downstream logic
  always_comb begin
    state_nxt = state;
    stab_nxt  = stab_cnt;
    case (state)
      WAIT_LOCK: begin
        stab_nxt = '0;
        if (lock_s) state_nxt = STABILISE;
      end
      STABILISE: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          stab_nxt  = '0;
        end else if (stab_cnt == STAB_LAST) begin
          state_nxt = RUN;
          stab_nxt  = '0;
        end else begin
          stab_nxt  = stab_cnt + 1'b1;
        end
      end
      RUN: begin
        if (!lock_s) state_nxt = FAULT;
      end
      FAULT: begin
        state_nxt = WAIT_LOCK;
      end
      default: begin
        state_nxt = WAIT_LOCK;
        stab_nxt  = '0;
      end
    endcase
  end

  // Registered status: reset release tracks RUN, loss flag is sticky, loss count saturates
  always_ff @(posedge PLLOUTGLOBAL or negedge RESET) begin
    if (!RESET) begin
      rst_sync_n <= 1'b0;
      ready      <= 1'b0;
      lock_lost  <= 1'b0;
      loss_count <= '0;
    end else begin
      rst_sync_n <= (state_nxt == RUN);
      ready      <= (state_nxt == RUN);
      if (state == FAULT) begin
        lock_lost <= 1'b1;
        if (loss_count != '1) loss_count <= loss_count + 1'b1;
      end
    end
  end

  // Channels run only while RUN persists; a wrap coinciding with lock loss is suppressed
  assign ce_en = (state == RUN) && lock_s;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic ch_load;
    assign ch_load = div_load && (div_ch == CH_IDX_W'(i));

    pc2drone_ce_div #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_div (
      .clk   (PLLOUTGLOBAL),
      .rst_n (RESET),
      .en    (ce_en),
      .load  (ch_load),
      .value (div_value),
      .ce    (ce[i])
    );
  end

endmodule

// File: tb/tb_pc2drone_clkgen.sv
// Directed bench for pc2drone_clkgen: lock sequencing, divider patterns, reload timing, lock loss and reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_pc2drone_clkgen;

  localparam int N_CH = 5;
  localparam int DIV_W = 16;
  localparam int S = 16;
  localparam int LW = 8;

  logic             clk = 1'b0;
  logic             RESET;
  logic             LOCK;
  logic             div_load;
  logic [2:0]       div_ch;
  logic [DIV_W-1:0] div_value;
  logic             rst_sync_n;
  logic             ready;
  logic [N_CH-1:0]  ce;
  logic             lock_lost;
  logic [LW-1:0]    loss_count;

  int n_cmp = 0;
  int n_err = 0;
  int kc = 0;

  always #5 clk = ~clk;

  pc2drone_clkgen #(
    .N_CH          (N_CH),
    .DIV_W         (DIV_W),
    .STABLE_CYCLES (S),
    .DEFAULT_DIV   (16'd1),
    .LOSS_CNT_W    (LW)
  ) dut (
    .PLLOUTGLOBAL (clk),
    .RESET        (RESET),
    .LOCK         (LOCK),
    .div_load     (div_load),
    .div_ch       (div_ch),
    .div_value    (div_value),
    .rst_sync_n   (rst_sync_n),
    .ready        (ready),
    .ce           (ce),
    .lock_lost    (lock_lost),
    .loss_count   (loss_count)
  );

  task automatic tick();
    @(negedge clk);
    kc++;
  endtask

  task automatic drive_load(input logic ld, input int ch, input int val);
    div_load  = ld;
    div_ch    = 3'(ch);
    div_value = 16'(val);
  endtask

  // Ticks until ready is seen; checks the cycle count and that ce stayed low meanwhile
  task automatic wait_ready(input string name, input int exp);
    int n;
    int ce_bad;
    n = 0;
    ce_bad = 0;
    do begin
      tick();
      n++;
      if (ready !== 1'b1 && ce !== '0) ce_bad++;
    end while (ready !== 1'b1 && n < 200);
    n_cmp++;
    if (n !== exp) begin
      n_err++;
      $display("FAIL %s_latency: ready after %0d cycles, expected %0d", name, n, exp);
    end
    n_cmp++;
    if (ce_bad !== 0) begin
      n_err++;
      $display("FAIL %s_ce_quiet: %0d cycles with ce set before ready, expected 0", name, ce_bad);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    LOCK = 1'b1;
    drive_load(1'b0, 0, 0);
    #3 RESET = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({rst_sync_n, ready} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_rdy: rst_sync_n/ready=%b expected 00", {rst_sync_n, ready});
    end
    n_cmp++;
    if (ce !== '0) begin
      n_err++;
      $display("FAIL reset_ce: ce=%b expected 0", ce);
    end
    n_cmp++;
    if ({lock_lost, loss_count} !== '0) begin
      n_err++;
      $display("FAIL reset_loss: lock_lost=%b loss_count=%0d expected 0/0", lock_lost, loss_count);
    end
  endtask

  // Release reset with LOCK high, program divisors while stabilising
  task automatic test_lock_sequence();
    int bad;
    bad = 0;
    RESET = 1'b1;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: drive_load(1'b1, 0, 4);
        1: drive_load(1'b1, 1, 1);
        2: drive_load(1'b1, 2, 0);
        default: drive_load(1'b1, 3, 10);
      endcase
      tick();
      if (ready !== 1'b0 || ce !== '0) bad++;
    end
    drive_load(1'b0, 0, 0);
    n_cmp++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL early_outputs: %0d cycles with ready/ce set, expected 0", bad);
    end
    wait_ready("release", S + 3 - 4);
    n_cmp++;
    if (rst_sync_n !== 1'b1) begin
      n_err++;
      $display("FAIL release_rst: rst_sync_n=%b expected 1", rst_sync_n);
    end
  endtask

  task automatic test_ce_pattern();
    logic [N_CH-1:0] exp;
    kc = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      exp = {1'b1, (kc % 10 == 0), 1'b1, 1'b1, (kc % 4 == 0)};
      n_cmp++;
      if (ce !== exp) begin
        n_err++;
        $display("FAIL ce_pattern k=%0d: ce=%b expected %b", kc, ce, exp);
      end
    end
  endtask

  // ch0 4->8 then 3 mid-period, ch3 double write, out-of-range writes
  task automatic test_reload();
    logic [N_CH-1:0] exp;
    logic e0;
    logic e3;
    for (int i = 0; i < 24; i++) begin
      case (kc)
        20: drive_load(1'b1, 0, 8);
        21: drive_load(1'b1, 3, 5);
        22: drive_load(1'b1, 3, 6);
        26: drive_load(1'b1, 0, 3);
        27: drive_load(1'b1, 5, 2);
        28: drive_load(1'b1, 7, 2);
        default: drive_load(1'b0, 0, 0);
      endcase
      tick();
      e0 = (kc == 24) || (kc == 32) || (kc > 32 && (kc - 32) % 3 == 0);
      e3 = (kc == 30) || (kc > 30 && (kc - 30) % 6 == 0);
      exp = {1'b1, e3, 1'b1, 1'b1, e0};
      n_cmp++;
      if (ce !== exp) begin
        n_err++;
        $display("FAIL reload k=%0d: ce=%b expected %b", kc, ce, exp);
      end
    end
    drive_load(1'b0, 0, 0);
  endtask

  // LOCK drops in RUN on a ch0 wrap; then re-lock keeps divisors
  task automatic test_lock_loss();
    logic [N_CH-1:0] exp;
    LOCK = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (ready !== 1'b1) begin
      n_err++;
      $display("FAIL loss_early: ready=%b expected 1 two cycles after drop", ready);
    end
    tick();
    n_cmp++;
    if ({ready, rst_sync_n} !== 2'b00) begin
      n_err++;
      $display("FAIL loss_rdy: ready/rst_sync_n=%b expected 00", {ready, rst_sync_n});
    end
    n_cmp++;
    if (ce !== '0) begin
      n_err++;
      $display("FAIL loss_ce: ce=%b expected 0 (wrap suppressed)", ce);
    end
    tick();
    n_cmp++;
    if (lock_lost !== 1'b1 || loss_count !== 8'd1) begin
      n_err++;
      $display("FAIL loss_flag: lock_lost=%b loss_count=%0d expected 1/1", lock_lost, loss_count);
    end
    LOCK = 1'b1;
    wait_ready("relock", S + 3);
    kc = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      exp = {1'b1, (kc % 6 == 0), 1'b1, 1'b1, (kc % 3 == 0)};
      n_cmp++;
      if (ce !== exp) begin
        n_err++;
        $display("FAIL kept_div k=%0d: ce=%b expected %b", kc, ce, exp);
      end
    end
  endtask

  // One-cycle lock glitch seen while the stability counter is at 8
  task automatic test_glitch();
    LOCK = 1'b0;
    repeat (6) tick();
    LOCK = 1'b1;
    repeat (9) tick();
    LOCK = 1'b0;
    tick();
    LOCK = 1'b1;
    wait_ready("glitch", S + 3);
    n_cmp++;
    if (loss_count !== 8'd2) begin
      n_err++;
      $display("FAIL glitch_count: loss_count=%0d expected 2", loss_count);
    end
  endtask

  task automatic test_saturation();
    int timeouts;
    int n;
    timeouts = 0;
    for (int i = 0; i < 256; i++) begin
      LOCK = 1'b0;
      repeat (4) tick();
      LOCK = 1'b1;
      n = 0;
      do begin
        tick();
        n++;
      end while (ready !== 1'b1 && n < 40);
      if (ready !== 1'b1) timeouts++;
    end
    n_cmp++;
    if (timeouts !== 0) begin
      n_err++;
      $display("FAIL sat_timeout: %0d re-locks without ready, expected 0", timeouts);
    end
    n_cmp++;
    if (loss_count !== 8'hFF) begin
      n_err++;
      $display("FAIL sat_count: loss_count=%0d expected 255", loss_count);
    end
    n_cmp++;
    if (lock_lost !== 1'b1) begin
      n_err++;
      $display("FAIL sat_flag: lock_lost=%b expected 1", lock_lost);
    end
  endtask

  // Asynchronous reset mid-RUN, then divisors back to default (ce every cycle)
  task automatic test_reset_mid_run();
    repeat (3) tick();
    n_cmp++;
    if (ce[1] !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset_ce1: ce[1]=%b expected 1", ce[1]);
    end
    #2 RESET = 1'b0;
    #1;
    n_cmp++;
    if ({rst_sync_n, ready, ce, lock_lost} !== '0) begin
      n_err++;
      $display("FAIL async_reset: rst_sync_n/ready/ce/lock_lost=%b expected 0", {rst_sync_n, ready, ce, lock_lost});
    end
    n_cmp++;
    if (loss_count !== 8'd0) begin
      n_err++;
      $display("FAIL async_reset_count: loss_count=%0d expected 0", loss_count);
    end
    tick();
    tick();
    RESET = 1'b1;
    wait_ready("post_reset", S + 3);
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++;
      if (ce !== 5'h1F) begin
        n_err++;
        $display("FAIL default_div i=%0d: ce=%b expected 11111", i, ce);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock_sequence();
    test_ce_pattern();
    test_reload();
    test_lock_loss();
    test_glitch();
    test_saturation();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
